// File: rtl/traffic_light_controller_param.sv
// Highway / local-road intersection controller.
// The highway rests on green and yields to the local road only after a minimum
// green time, and only when a car is waiting there. The local-road green has a
// minimum and a maximum length. Yellow and all-red clearance phases separate the
// two greens. The lights are a pure function of the state (Moore).
//
// Handshake: none. LR_has_Car is a level that is sampled on every rising CLK.
// It only influences the HW_G and LR_G states.
module traffic_light_controller_param #(
  parameter int HW_MIN_GREEN = 6,
  parameter int YELLOW       = 2,
  parameter int ALL_RED      = 1,
  parameter int LR_MIN_GREEN = 2,
  parameter int LR_MAX_GREEN = 6,
  parameter int CW           = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LR_has_Car,
  output logic [2:0] HW_light,
  output logic [2:0] LR_light,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_HW_G = 3'd0,
    S_HW_Y = 3'd1,
    S_AR1  = 3'd2,
    S_LR_G = 3'd3,
    S_LR_Y = 3'd4,
    S_AR2  = 3'd5
  } state_t;

  // Light encodings {G,Y,R}
  localparam logic [2:0] L_GREEN  = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b001;

  // Counter value at which each phase may end (duration - 1)
  localparam logic [CW-1:0] L_HW_LAST     = CW'(HW_MIN_GREEN - 1);
  localparam logic [CW-1:0] L_YEL_LAST    = CW'(YELLOW - 1);
  localparam logic [CW-1:0] L_AR_LAST     = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] L_LR_MIN_LAST = CW'(LR_MIN_GREEN - 1);
  localparam logic [CW-1:0] L_LR_MAX_LAST = CW'(LR_MAX_GREEN - 1);
  localparam logic [CW-1:0] L_ONE         = CW'(1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_hw_light;
  logic [2:0]    w_lr_light;

  // State and phase-counter registers; reset forces HW_G with the counter cleared
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_HW_G;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state rules. Any unused code falls back to HW_G on the next edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HW_G: if ((r_cnt >= L_HW_LAST) && LR_has_Car) w_next_state = S_HW_Y;
      S_HW_Y: if (r_cnt == L_YEL_LAST)                w_next_state = S_AR1;
      S_AR1:  if (r_cnt == L_AR_LAST)                 w_next_state = S_LR_G;
      S_LR_G: if ((r_cnt == L_LR_MAX_LAST) ||
                  ((r_cnt >= L_LR_MIN_LAST) && !LR_has_Car))
                                                      w_next_state = S_LR_Y;
      S_LR_Y: if (r_cnt == L_YEL_LAST)                w_next_state = S_AR2;
      S_AR2:  if (r_cnt == L_AR_LAST)                 w_next_state = S_HW_G;
      default:                                        w_next_state = S_HW_G;
    endcase
  end

  // Phase counter: cleared on every state change. It saturates in HW_G so that
  // an idle highway never wraps. Other states always leave before they overflow.
  always_comb begin
    w_cnt_next = r_cnt + L_ONE;
    if (w_next_state != r_state) begin
      w_cnt_next = '0;
    end else if ((r_state == S_HW_G) && (r_cnt >= L_HW_LAST)) begin
      w_cnt_next = r_cnt;
    end
  end

  // Light decode from state only. Unused codes show red both ways.
  always_comb begin
    w_hw_light = L_RED;
    w_lr_light = L_RED;
    case (r_state)
      S_HW_G:  w_hw_light = L_GREEN;
      S_HW_Y:  w_hw_light = L_YELLOW;
      S_LR_G:  w_lr_light = L_GREEN;
      S_LR_Y:  w_lr_light = L_YELLOW;
      default: begin
        w_hw_light = L_RED;
        w_lr_light = L_RED;
      end
    endcase
  end

  assign HW_light = w_hw_light;
  assign LR_light = w_lr_light;
  assign phase    = r_state;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Bench for traffic_light_controller_param.
// Two instances run on the same stimulus: one with the default parameters, and
// one with YELLOW=3 and ALL_RED=2. A phase-and-elapsed-time reference model
// predicts the lights and the phase of each instance.
module tb_traffic_light_controller_param;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       car   = 1'b0;
  logic [2:0] hw_a, lr_a, ph_a;
  logic [2:0] hw_b, lr_b, ph_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  // Reference model state and parameters, per instance (0 = default, 1 = slow clearance)
  int m_ph[2];
  int m_el[2];
  int p_hwmin[2] = '{6, 6};
  int p_yel[2]   = '{2, 3};
  int p_ar[2]    = '{1, 2};
  int p_lrmin[2] = '{2, 2};
  int p_lrmax[2] = '{6, 6};

  traffic_light_controller_param dut_a (
    .CLK(CLK), .RESET(RESET), .LR_has_Car(car),
    .HW_light(hw_a), .LR_light(lr_a), .phase(ph_a)
  );

  traffic_light_controller_param #(.YELLOW(3), .ALL_RED(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .LR_has_Car(car),
    .HW_light(hw_b), .LR_light(lr_b), .phase(ph_b)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {HW, LR} lights for each phase
  function automatic logic [5:0] lights_of(input int ph);
    case (ph)
      0:       return {3'b100, 3'b001};
      1:       return {3'b010, 3'b001};
      3:       return {3'b001, 3'b100};
      4:       return {3'b001, 3'b010};
      default: return {3'b001, 3'b001};
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0;
      m_el[k] = 0;
    end
  endfunction

  // One rising edge. el counts the edges spent in the current phase.
  function automatic void model_step(input int k, input logic c, input logic rst);
    int nx;
    int e;
    if (rst) begin
      m_ph[k] = 0;
      m_el[k] = 0;
      return;
    end
    nx = m_ph[k];
    e  = m_el[k];
    case (m_ph[k])
      0: if (e >= p_hwmin[k] - 1 && c)                          nx = 1;
      1: if (e == p_yel[k] - 1)                                 nx = 2;
      2: if (e == p_ar[k] - 1)                                  nx = 3;
      3: if (e == p_lrmax[k] - 1 || (e >= p_lrmin[k] - 1 && !c)) nx = 4;
      4: if (e == p_yel[k] - 1)                                 nx = 5;
      5: if (e == p_ar[k] - 1)                                  nx = 0;
      default:                                                  nx = 0;
    endcase
    if (nx != m_ph[k]) begin
      m_ph[k] = nx;
      m_el[k] = 0;
    end else begin
      m_el[k] = e + 1;
    end
  endfunction

  task automatic check_all();
    logic [5:0] ea, eb;
    ea = lights_of(m_ph[0]);
    eb = lights_of(m_ph[1]);
    check("a_phase", ph_a, m_ph[0]);
    check("a_hw",    hw_a, ea[5:3]);
    check("a_lr",    lr_a, ea[2:0]);
    check("a_excl",  (hw_a != 3'b001 && lr_a != 3'b001), 0);
    check("b_phase", ph_b, m_ph[1]);
    check("b_hw",    hw_b, eb[5:3]);
    check("b_lr",    lr_b, eb[2:0]);
    check("b_excl",  (hw_b != 3'b001 && lr_b != 3'b001), 0);
  endtask

  // Advance one clock. Outputs are checked at the following falling edge.
  task automatic cycle();
    @(posedge CLK);
    model_step(0, car, RESET);
    model_step(1, car, RESET);
    @(negedge CLK);
    check_all();
  endtask

  // Synchronous-looking reset pulse of one cycle. The bench returns at a falling edge.
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    car   = 1'b0;
    cycle();
    RESET = 1'b0;
  endtask

  // Hold car=1 until instance A shows LR_G, bounded
  task automatic wait_lr_g();
    int n;
    n = 0;
    car = 1'b1;
    while (ph_a != 3'd3 && n < 40) begin
      cycle();
      n++;
    end
    check("wait_lr_g", (ph_a == 3'd3), 1);
  endtask

  initial begin
    int bias;
    model_reset();
    // Reset state while RESET is held
    #3;
    check_all();
    @(negedge CLK);
    RESET = 1'b0;

    // Idle highway: no car for 20 cycles
    car = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("idle_hw", hw_a, 3'b100);
    end

    // Car constant from reset release: a fixed 19-cycle phase sequence
    do_reset();
    car = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(3'd0);
    for (int i = 0; i < 2; i++) exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    for (int i = 0; i < 6; i++) exp_q.push_back(3'd3);
    for (int i = 0; i < 2; i++) exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd0);
    check("seq_0", ph_a, exp_q.pop_front());
    for (int i = 1; i < 19; i++) begin
      cycle();
      check($sformatf("seq_%0d", i), ph_a, exp_q.pop_front());
    end

    // Late car: HW_Y on the first edge that samples it
    do_reset();
    car = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    car = 1'b1;
    cycle();
    check("late_car_hwy", ph_a, 3'd1);

    // Car held one LR-green cycle, then dropped: two LR-green cycles
    do_reset();
    wait_lr_g();
    cycle();
    car = 1'b0;
    cycle();
    check("lr_min_held", ph_a, 3'd4);

    // Car dropped on LR-green entry: still two LR-green cycles
    do_reset();
    wait_lr_g();
    car = 1'b0;
    cycle();
    check("lr_min_drop_a", ph_a, 3'd3);
    cycle();
    check("lr_min_drop_b", ph_a, 3'd4);

    // Asynchronous reset between edges during LR_G
    do_reset();
    wait_lr_g();
    @(posedge CLK);
    model_step(0, car, RESET);
    model_step(1, car, RESET);
    #2 RESET = 1'b1;
    model_reset();
    #1;
    check("async_hw", hw_a, 3'b100);
    check("async_lr", lr_a, 3'b001);
    check("async_ph", ph_a, 3'd0);
    check_all();
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 30; i++) cycle();

    // Randomized traffic with occasional asynchronous resets
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) bias = $urandom_range(5, 95);
      car = ($urandom_range(0, 99) < bias);
      if ($urandom_range(0, 199) == 0) begin
        RESET = 1'b1;
        model_reset();
        #1;
        check_all();
      end else begin
        RESET = 1'b0;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller_param.md
TRAFFIC_LIGHT_CONTROLLER_PARAM -- requirements
Module: traffic_light_controller_param

Interface
REQ-001 SHALL have parameter HW_MIN_GREEN, default 6, meaning minimum highway-green cycles before yielding.
REQ-002 SHALL have parameter YELLOW, default 2, meaning yellow duration in cycles, both roads.
REQ-003 SHALL have parameter ALL_RED, default 1, meaning all-red clearance cycles between greens.
REQ-004 SHALL have parameter LR_MIN_GREEN, default 2, meaning minimum local-road green cycles.
REQ-005 SHALL have parameter LR_MAX_GREEN, default 6, meaning maximum local-road green cycles.
REQ-006 SHALL have parameter CW, default 8, meaning phase-counter width; every duration is >=1 and <2^CW, and LR_MIN_GREEN <= LR_MAX_GREEN.
REQ-007 SHALL have port CLK  input  1  single clock, rising edge.
REQ-008 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port LR_has_Car  input  1  local-road vehicle present, sampled at rising CLK.
REQ-010 SHALL have port HW_light  output  3  highway light {G,Y,R}: 100 green, 010 yellow, 001 red.
REQ-011 SHALL have port LR_light  output  3  local-road light, same encoding.
REQ-012 SHALL have port phase  output  3  current state code for observation.

Function
REQ-013 SHALL implement a Moore FSM with states HW_G=0, HW_Y=1, AR1=2, LR_G=3, LR_Y=4, AR2=5; codes 6-7 are unreachable and SHALL return to HW_G on the next edge.
REQ-014 SHALL drive lights only from state: HW_G 100/001, HW_Y 010/001, AR1 001/001, LR_G 001/100, LR_Y 001/010, AR2 001/001 (HW/LR).
REQ-015 SHALL keep a CW-bit phase counter cnt that is 0 on entry to any state and increments by one on each edge that does not leave the state.
REQ-016 SHALL saturate cnt in HW_G at HW_MIN_GREEN-1; in no state does it wrap.
REQ-017 HW_G -> HW_Y at an edge where cnt >= HW_MIN_GREEN-1 and LR_has_Car=1; otherwise remain indefinitely.
REQ-018 HW_Y -> AR1 at the edge where cnt = YELLOW-1; AR1 -> LR_G at the edge where cnt = ALL_RED-1.
REQ-019 LR_G -> LR_Y at the edge where cnt = LR_MAX_GREEN-1, or earlier at an edge where cnt >= LR_MIN_GREEN-1 and LR_has_Car=0.
REQ-020 LR_Y -> AR2 at cnt = YELLOW-1; AR2 -> HW_G at cnt = ALL_RED-1.
REQ-021 SHALL ignore LR_has_Car in HW_Y, AR1, LR_Y and AR2; a car arriving then is served only through the HW_G rule.
REQ-022 SHALL never present green or yellow on both roads in the same cycle.
REQ-023 When duration parameter = 1, the state SHALL last exactly one cycle.

Reset
REQ-024 While RESET=1, state SHALL be HW_G, cnt=0, HW_light=100, LR_light=001, phase=0, independent of CLK.
REQ-025 RESET assertion mid-phase SHALL take effect immediately without a clock edge; after release, timing restarts from HW_G cnt=0.

Verification
REQ-026 Reset, then LR_has_Car=0 for 20 cycles -> HW_light=100, LR_light=001, phase=0 every cycle.
REQ-027 Defaults, LR_has_Car=1 constant from reset release -> HW 100 for 6 cycles, HW 010 for 2, all 001 for 1, LR 100 for 6, LR 010 for 2, all 001 for 1, then HW 100 again (cycle 19).
REQ-028 Defaults, LR_has_Car=0 for 10 cycles then 1 -> HW_Y entered at the first edge sampling the 1 (cnt already saturated).
REQ-029 Defaults, car held until 2 LR-green cycles have elapsed, then dropped -> LR yellow after exactly 2 LR-green cycles; car dropped after 1 LR-green cycle -> still 2 LR-green cycles.
REQ-030 RESET pulsed asynchronously between edges during LR_G -> HW_light=100, LR_light=001 before next edge; normal sequence resumes after release.
REQ-031 YELLOW=3, ALL_RED=2, car constant -> each yellow lasts 3 cycles and each all-red 2 cycles; REQ-022 holds throughout.
